// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte write handshake and serial-line status of the buffered UART transmitter.
interface uart_tx_fifo_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;
    logic       o_Overflow;
    modport master (output i_Tx_DV, i_Tx_Byte,
                    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Overflow);
    modport slave  (input  i_Tx_DV, i_Tx_Byte,
                    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO, sending back-to-back frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           i_Clock,
    input logic           i_Reset,
    uart_tx_fifo_if.slave tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data;
    logic          serial, active, done, ovf;
    logic          full, wr, bit_end, pop;
    // Fullness is judged before any pop on the same edge, so a write to a full FIFO is always dropped.
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign wr      = tx.i_Tx_DV && !full;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign pop     = count != 0 && (state == IDLE || (state == STOP && bit_end));
    assign tx.o_Tx_Ready  = !full;
    assign tx.o_Tx_Active = active;
    assign tx.o_Tx_Serial = serial;
    assign tx.o_Tx_Done   = done;
    assign tx.o_Overflow  = ovf;
    always_ff @(posedge i_Clock) begin
        if (wr) mem[wr_ptr] <= tx.i_Tx_Byte;
    end
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            idx    <= '0;
            data   <= '0;
            serial <= 1'b1;
            active <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done   <= 1'b0;
            ovf    <= tx.i_Tx_DV && full;
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
            cnt    <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (pop) begin
                    state  <= START;
                    data   <= mem[rd_ptr];
                    serial <= 1'b0;
                    active <= 1'b1;
                end
                START: if (bit_end) begin
                    state  <= DATA;
                    idx    <= '0;
                    serial <= data[0];
                end
                DATA: if (bit_end) begin
                    if (idx == 3'd7) begin
                        state  <= STOP;
                        idx    <= '0;
                        serial <= 1'b1;
                    end else begin
                        idx    <= idx + 3'd1;
                        serial <= data[idx + 3'd1];
                    end
                end
                STOP: if (bit_end) begin
                    done <= 1'b1;
                    if (pop) begin
                        state  <= START;
                        data   <= mem[rd_ptr];
                        serial <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz clock, 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of byte entries buffered (power of two, 2..16).
REQ-003 SHALL have port i_Clock  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port i_Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_Tx_DV  input  1  write strobe; one byte offered per cycle high.
REQ-006 SHALL have port i_Tx_Byte  input  8  byte to transmit, sampled when i_Tx_DV high.
REQ-007 SHALL have port o_Tx_Ready  output  1  high when FIFO not full (write will be accepted).
REQ-008 SHALL have port o_Tx_Active  output  1  high while a frame (start..stop) is on the line.
REQ-009 SHALL have port o_Tx_Serial  output  1  serial line, idle high, registered output.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse at end of each stop bit.
REQ-011 SHALL have port o_Overflow  output  1  one-cycle pulse when a write is dropped because FIFO full.

Function
REQ-012 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop same edge); START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8th bit; STOP->START if FIFO non-empty at stop end (pop same edge), else STOP->IDLE.
REQ-014 SHALL use bit-period counter 0..CLKS_PER_BIT-1 and 3-bit bit index, both cleared on every state change.
REQ-015 SHALL drive o_Tx_Serial low on the first clock edge after the edge that writes into an empty FIFO while IDLE (1-cycle latency).
REQ-016 SHALL send back-to-back frames with no idle cycles between stop bit and next start bit when FIFO is non-empty.
REQ-017 SHALL latch popped byte into a shift register; later FIFO writes SHALL NOT alter the frame in flight.
REQ-018 SHALL accept a write only when o_Tx_Ready high at that edge (fullness evaluated before any same-edge pop); a write while full SHALL be dropped, FIFO unchanged, o_Overflow pulsed next cycle.
REQ-019 SHALL support simultaneous write and pop when not full; occupancy unchanged, order preserved.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-021 SHALL assert o_Tx_Done for exactly one cycle on the edge the stop bit period completes, including between back-to-back frames.
REQ-022 SHALL hold o_Tx_Active high in START, DATA, STOP; low in IDLE.

Reset
REQ-023 SHALL, on i_Reset high, asynchronously force o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Tx_Ready=1, FSM=IDLE, FIFO empty, counters 0.
REQ-024 SHALL abort any frame in progress on reset; queued bytes discarded, no partial resumption after release.
REQ-025 SHALL ignore i_Tx_DV while i_Reset high; first write accepted on first edge after release.

Verification
REQ-026 Single byte: CLKS_PER_BIT=8, write 8'd50 -> serial 0,0,1,0,0,1,1,0,0,1 each 8 cycles, start bit 1 cycle after write, one o_Tx_Done pulse at cycle 80.
REQ-027 Back-to-back: write 48,49,50 on consecutive cycles -> three frames, 240 cycles, no idle gap, three o_Tx_Done pulses 80 cycles apart.
REQ-028 Overflow: DEPTH=4, write 6 bytes consecutively while line busy -> 5 accepted (1 in shift reg + 4 queued), 6th dropped with one o_Overflow pulse, o_Tx_Ready low until first pop.
REQ-029 Reset mid-frame: assert i_Reset during DATA bit 3 with 2 bytes queued -> o_Tx_Serial=1 immediately, no further frames after release, o_Tx_Ready=1.
REQ-030 Loopback: CLKS_PER_BIT=5208, o_Tx_Serial into existing uart_rx, send 48,49,50 -> receiver bytes match, o_DriveCMD = 0,1,2 in order.
